// File: rtl/alu_pkg.sv
// Shared funct codes and multiplier state encoding for the pipelined ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier producing {hi,lo}.
// Latency: WIDTH+1 busy cycles after start (WIDTH RUN steps plus one DONE write).
// Backpressure: start is only honoured in IDLE; busy tells the issuer to hold off.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mul_state_e       r_state;
  mul_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   w_sum;

  // Partial-product add is one bit wider so the carry shifts into acc.
  assign w_sum = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: IDLE -> RUN on start, RUN for WIDTH steps, one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == CNT_LAST) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands, shift-add each RUN step, commit hi/lo only in DONE
  // so an aborted multiply never leaves a partial product behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_acc    <= w_sum[WIDTH:1];
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
        end
        DONE: begin
          r_hi <= r_acc;
          r_lo <= r_mplier;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// EX-stage ALU with extended funct set, internal HI/LO and a sequential MULTU.
// Latency: LATENCY cycles from accept to out_valid; MULTU leaves a bubble.
// Backpressure: in_ready drops while the multiplier runs; no downstream stall.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int LATENCY = 2,
  localparam int SHW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] dataOut,
  output logic             illegal,
  output logic             mul_busy
);

  logic             w_accept;
  logic             w_start;
  logic             w_in_vld;
  logic             w_mul_done;
  logic             w_unused_done;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_diff;
  logic             w_carry;
  logic             w_ovf;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_ill;

  logic             r_vld [LATENCY];
  logic [WIDTH-1:0] r_res [LATENCY];
  logic             r_ill [LATENCY];

  assign in_ready      = ~mul_busy;
  assign w_accept      = in_valid & in_ready;
  assign w_start       = w_accept & (Signal == F_MULTU);
  assign w_in_vld      = w_accept & (Signal != F_MULTU);
  assign w_unused_done = w_mul_done;

  // Shared subtractor: carry-out gives SLTU, sign xor overflow gives SLT.
  assign {w_carry, w_diff} = {1'b0, dataA} + {1'b0, ~dataB} + {{WIDTH{1'b0}}, 1'b1};
  assign w_ovf = (dataA[WIDTH-1] ^ dataB[WIDTH-1]) & (w_diff[WIDTH-1] ^ dataA[WIDTH-1]);
  assign w_slt = w_diff[WIDTH-1] ^ w_ovf;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .a     (dataA),
    .b     (dataB),
    .busy  (mul_busy),
    .done  (w_mul_done),
    .hi    (w_hi),
    .lo    (w_lo)
  );

  // Result select; unknown functs yield 0 with the illegal flag set.
  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (Signal)
      F_ADD:   w_res = dataA + dataB;
      F_SUB:   w_res = w_diff;
      F_AND:   w_res = dataA & dataB;
      F_OR:    w_res = dataA | dataB;
      F_XOR:   w_res = dataA ^ dataB;
      F_NOR:   w_res = ~(dataA | dataB);
      F_SLT:   w_res = {{(WIDTH-1){1'b0}}, w_slt};
      F_SLTU:  w_res = {{(WIDTH-1){1'b0}}, ~w_carry};
      F_SLL:   w_res = dataB << shamt;
      F_SRL:   w_res = dataB >> shamt;
      F_SRA:   w_res = $unsigned($signed(dataB) >>> shamt);
      F_MFHI:  w_res = w_hi;
      F_MFLO:  w_res = w_lo;
      F_MULTU: w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end

  // LATENCY-deep result pipeline; bubbles carry zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_res[i] <= '0;
        r_ill[i] <= 1'b0;
      end
    end else begin
      r_vld[0] <= w_in_vld;
      r_res[0] <= w_in_vld ? w_res : '0;
      r_ill[0] <= w_in_vld & w_ill;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_res[i] <= r_res[i-1];
        r_ill[i] <= r_ill[i-1];
      end
    end
  end

  assign out_valid = r_vld[LATENCY-1];
  assign dataOut   = r_res[LATENCY-1];
  assign illegal   = r_ill[LATENCY-1];

endmodule
